// File: rtl/branch_pkg.sv
// Shared types and constants for the branch flag producer.
// Optional feature macro: BRANCH_UNSIGNED_EN adds the unsigned less-than flag to the packet.
package branch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Branch funct3 encodings
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct packed {
`ifdef BRANCH_UNSIGNED_EN
    logic       less_unsigned;
`endif
    logic       zero;
    logic       less;
    logic       less_or_equal;
    logic       branch;
    logic [2:0] branch_type;
  } flag_pkt_t;

endpackage

// File: rtl/branch_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready_o depends only on registered occupancy.
module branch_skid_buf #(
  parameter int unsigned Width = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  if (DEPTH != 2) begin : gen_depth_check
    $error("branch_skid_buf supports DEPTH == 2 only");
  end

  logic [1:0]       count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             in_xfer, out_xfer;

  assign in_ready_o  = (count_q < 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  // Occupancy and entry update; flush wins over any transfer in the same cycle
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (in_xfer) begin
            head_d  = in_data_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (in_xfer && out_xfer) begin
            head_d = in_data_i;
          end else if (in_xfer) begin
            tail_d  = in_data_i;
            count_d = 2'd2;
          end else if (out_xfer) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // Full: in_ready is low, so only the output side can move
          if (out_xfer) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/branch_flag_gen.sv
// Branch flag producer: compares rs1/rs2 and buffers the flag packet behind a skid buffer.
// Optional feature macro: BRANCH_UNSIGNED_EN adds the less_unsigned output.
module branch_flag_gen
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            branch_in,
  input  logic [2:0]      branch_type_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            branch,
  output logic [2:0]      branch_type,
  output logic            zero,
  output logic            less,
`ifdef BRANCH_UNSIGNED_EN
  output logic            less_unsigned,
`endif
  output logic            less_or_equal
);

  localparam int unsigned PktW = $bits(flag_pkt_t);

  flag_pkt_t pkt_in, pkt_out;

  // Full-width compare of the incoming operands
  always_comb begin
    pkt_in               = '0;
    pkt_in.zero          = (rs1_data == rs2_data);
    pkt_in.less          = ($signed(rs1_data) < $signed(rs2_data));
    pkt_in.less_or_equal = pkt_in.less | pkt_in.zero;
`ifdef BRANCH_UNSIGNED_EN
    pkt_in.less_unsigned = (rs1_data < rs2_data);
`endif
    pkt_in.branch        = branch_in;
    pkt_in.branch_type   = branch_type_in;
  end

  branch_skid_buf #(
    .Width (PktW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pkt_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pkt_out)
  );

  assign branch        = pkt_out.branch;
  assign branch_type   = pkt_out.branch_type;
  assign zero          = pkt_out.zero;
  assign less          = pkt_out.less;
  assign less_or_equal = pkt_out.less_or_equal;
`ifdef BRANCH_UNSIGNED_EN
  assign less_unsigned = pkt_out.less_unsigned;
`endif

endmodule

// File: tb/tb_branch_flag_gen.sv
// Self-checking bench for branch_flag_gen: vector table plus handshake corner sequences.
module tb_branch_flag_gen;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data, rs2_data;
  logic        branch_in;
  logic [2:0]  branch_type_in;
  logic        out_valid;
  logic        out_ready;
  logic        branch;
  logic [2:0]  branch_type;
  logic        zero, less, less_or_equal;
`ifdef BRANCH_UNSIGNED_EN
  logic        less_unsigned;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_flag_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .branch_in      (branch_in),
    .branch_type_in (branch_type_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .branch         (branch),
    .branch_type    (branch_type),
    .zero           (zero),
    .less           (less),
`ifdef BRANCH_UNSIGNED_EN
    .less_unsigned  (less_unsigned),
`endif
    .less_or_equal  (less_or_equal)
  );

  // {branch, branch_type, zero, less, less_or_equal}
  logic [6:0] obs;
  assign obs = {branch, branch_type, zero, less, less_or_equal};

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br;
    logic [2:0]  bt;
    logic [2:0]  flags;  // {zero, less, less_or_equal}
    logic        ltu;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic [2:0] bt);
    in_valid       = v;
    rs1_data       = a;
    rs2_data       = b;
    branch_in      = br;
    branch_type_in = bt;
  endtask

  // Stop input, let the buffer empty out
  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] ef;
    vecs[0] = '{32'd5,        32'd5,        1'b1, BEQ,  3'b101, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd1,        1'b1, BLT,  3'b011, 1'b0};
    vecs[2] = '{32'd1,        32'hFFFFFFFF, 1'b1, BGE,  3'b000, 1'b1};
    vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, BLT,  3'b011, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, BGE,  3'b000, 1'b1};
    vecs[5] = '{32'd0,        32'd0,        1'b0, BNE,  3'b101, 1'b0};
    vecs[6] = '{32'd3,        32'd10,       1'b1, BLTU, 3'b011, 1'b1};
    vecs[7] = '{32'd10,       32'd3,        1'b1, BGEU, 3'b000, 1'b0};
    vecs[8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, BGE,  3'b011, 1'b1};
    vecs[9] = '{32'h80000000, 32'h80000000, 1'b0, 3'b010, 3'b101, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_outputs", {25'd0, obs}, 32'd0);
`ifdef BRANCH_UNSIGNED_EN
    check("reset_ltu", {31'd0, less_unsigned}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, streamed with out_ready high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].br, vecs[i].bt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("vec%0d_pkt", i), {25'd0, obs},
            {25'd0, vecs[i].br, vecs[i].bt, vecs[i].flags});
`ifdef BRANCH_UNSIGNED_EN
      check($sformatf("vec%0d_ltu", i), {31'd0, less_unsigned}, {31'd0, vecs[i].ltu});
`endif
    end
    drain();

    // Backpressure: A, B accepted, C held off, then delivered in order
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 1'b1, BLT);      // A
    @(negedge clk);
    drive(1'b1, 32'd2, 32'd2, 1'b1, BEQ);      // B
    @(posedge clk);
    #1;
    check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_head_a", {25'd0, obs}, {25'd0, 7'b1_100_011});
    @(negedge clk);
    drive(1'b1, 32'd3, 32'd2, 1'b1, BGE);      // C
    @(posedge clk);
    #1;
    check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_head_a", {25'd0, obs}, {25'd0, 7'b1_100_011});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_head_b", {25'd0, obs}, {25'd0, 7'b1_000_101});
    check("bp_one_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_head_c", {25'd0, obs}, {25'd0, 7'b1_101_000});
    check("bp_c_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous in/out at count 1, operands incrementing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, i, 32'd4, 1'b1, 3'(i));
      ef = {(i == 4), (i < 4), (i <= 4)};
      @(posedge clk);
      #1;
      check($sformatf("sim%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("sim%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("sim%0d_pkt", i), {25'd0, obs}, {25'd0, 1'b1, 3'(i), ef});
    end
    drain();

    // Flush at count 2 with a packet presented
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd9, 1'b1, BEQ);
    @(negedge clk);
    drive(1'b1, 32'd8, 32'd9, 1'b1, BNE);
    @(posedge clk);
    #1;
    check("fl_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 32'd0, 32'd1, 1'b1, BGEU);
    @(posedge clk);
    #1;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("fl_quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 32'd7, 32'd6, 1'b0, BLTU);
    @(posedge clk);
    #1;
    check("fl_next_pkt", {25'd0, obs}, {25'd0, 7'b0_110_000});
    drain();

    // Asynchronous reset with the buffer full
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 1'b1, BEQ);
    @(negedge clk);
    drive(1'b1, 32'd2, 32'd1, 1'b1, BLT);
    @(posedge clk);
    #1;
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_outputs", {25'd0, obs}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("ar_stay_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
